// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder: formats, ALU codes,
// opcodes, FSM states and the terminator word.
package instr_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_LOAD = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6,
        FMT_BAD  = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_TERM  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // ALU codes are shared with the decode controller.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_OR   = 4'd7;
    localparam logic [3:0] ALU_AND  = 4'd8;
    localparam logic [3:0] ALU_SUB  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] TERMINATOR = 32'h0000006F;

    function automatic logic [2:0] alu_funct3(input logic [3:0] op);
        logic [2:0] f3;
        f3 = 3'b000;
        case (op)
            ALU_SLL:          f3 = 3'b001;
            ALU_SLT:          f3 = 3'b010;
            ALU_SLTU:         f3 = 3'b011;
            ALU_XOR:          f3 = 3'b100;
            ALU_SRL, ALU_SRA: f3 = 3'b101;
            ALU_OR:           f3 = 3'b110;
            ALU_AND:          f3 = 3'b111;
            default:          f3 = 3'b000;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer and legality checker.
module instr_pack
    import instr_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [3:0]  alu_op,
    input  logic [2:0]  f3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic       fits12;
    logic       fits13;
    logic       fits21;
    logic       is_shift;
    logic [2:0] op_f3;
    logic [6:0] funct7;

    // A value fits N signed bits when every bit above N-1 copies the sign bit.
    assign fits12   = (imm[31:11] == {21{imm[11]}});
    assign fits13   = (imm[31:12] == {20{imm[12]}});
    assign fits21   = (imm[31:20] == {12{imm[20]}});
    assign is_shift = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
    assign op_f3    = alu_funct3(alu_op);
    assign funct7   = (alu_op == ALU_SRA || alu_op == ALU_SUB) ? 7'b0100000 : 7'b0000000;

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt_e'(fmt))
            FMT_R: begin
                word    = {funct7, rs2, rs1, op_f3, rd, OPC_OP};
                illegal = (alu_op > ALU_SUB);
            end
            FMT_I: begin
                if (is_shift) begin
                    word    = {funct7, imm[4:0], rs1, op_f3, rd, OPC_OP_IMM};
                    illegal = (imm[31:5] != '0);
                end else begin
                    word    = {imm[11:0], rs1, op_f3, rd, OPC_OP_IMM};
                    illegal = !fits12 || (alu_op >= ALU_SUB);
                end
            end
            FMT_LOAD: begin
                word    = {imm[11:0], rs1, f3, rd, OPC_LOAD};
                illegal = !fits12 || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            FMT_S: begin
                word    = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
                illegal = !fits12 || (f3 > 3'b010);
            end
            FMT_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
                illegal = !fits13 || imm[0] || (f3 == 3'b010) || (f3 == 3'b011);
            end
            FMT_U: begin
                word = {imm[31:12], rd, OPC_LUI};
            end
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                illegal = !fits21 || imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: FSM, single-entry output register, address and word counter.
// Optional INSTR_ENC_TERMINATOR_EN appends jal x0,0 as the last word of each program.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fmt,
    input  logic [3:0]        req_alu_op,
    input  logic [2:0]        req_f3,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [31:0]       word_data,
    output logic [ADDR_W-1:0] word_addr,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count,
    output state_e            state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // producer holds its payload stable while valid is high and ready is low.
    state_e      state_next;
    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        term_load;
    logic        accept;
    logic        consume;
    logic        load;

    instr_pack u_pack (
        .fmt     (req_fmt),
        .alu_op  (req_alu_op),
        .f3      (req_f3),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .imm     (req_imm),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        done       = 1'b0;
        term_load  = 1'b0;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                req_ready = !finish && (!word_valid || word_ready);
                if (finish) begin
`ifdef INSTR_ENC_TERMINATOR_EN
                    state_next = ST_TERM;
`else
                    state_next = ST_DRAIN;
`endif
                end
            end
`ifdef INSTR_ENC_TERMINATOR_EN
            ST_TERM: begin
                if (!word_valid || word_ready) begin
                    term_load  = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
`endif
            ST_DRAIN: begin
                if (!word_valid) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept  = req_valid && req_ready;
    assign consume = word_valid && word_ready;
    assign load    = (accept && !pack_illegal) || term_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_addr  <= '0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start) begin
                word_addr  <= {start_addr[ADDR_W-1:2], 2'b00};
                err        <= 1'b0;
                word_count <= '0;
            end else if (consume) begin
                // word_addr tracks the slot of the current word, so it only moves on consume.
                word_addr <= word_addr + ADDR_W'(4);
                if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
            end
            if (accept && pack_illegal) err <= 1'b1;
            if (load) begin
                word_valid <= 1'b1;
                word_data  <= term_load ? TERMINATOR : pack_word;
            end else if (consume) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed RV32I encodings plus randomized
// requests against an arithmetic reference encoder and an in-order word scoreboard.
module tb_instr_encoder;
    import instr_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, finish, req_valid, word_ready;
    logic [31:0] start_addr, req_imm;
    logic [2:0]  req_fmt, req_f3;
    logic [3:0]  req_alu_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic        req_ready, word_valid, done, err;
    logic [31:0] word_data, word_addr;
    logic [15:0] word_count;
    state_e      dut_state;

    instr_encoder #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
        .req_alu_op(req_alu_op), .req_f3(req_f3), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm), .word_valid(word_valid),
        .word_ready(word_ready), .word_data(word_data), .word_addr(word_addr),
        .done(done), .err(err), .word_count(word_count), .state(dut_state)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] base;
    int          pushed;
    logic        exp_err;
    logic [15:0] exp_count;
    bit          rand_mode = 0;

    // Reference encoder built from the instruction-set field rules using integer arithmetic.
    function automatic void ref_encode(input int fmt, input int op, input int f3, input int rd,
                                       input int rs1, input int rs2, input logic [31:0] imm,
                                       output logic [31:0] w, output bit legal);
        int s;
        int op_f3[10] = '{0, 1, 2, 3, 4, 5, 5, 6, 7, 0};
        int r;
        s = $signed(imm);
        r = 0;
        legal = 0;
        case (fmt)
            0: begin
                legal = (op <= 9);
                if (legal) r = (((op == 6 || op == 9) ? 32 : 0) << 25) | (rs2 << 20) | (rs1 << 15)
                               | (op_f3[op] << 12) | (rd << 7) | 'h33;
            end
            1: begin
                if (op == 1 || op == 5 || op == 6) begin
                    legal = (s >= 0 && s <= 31);
                    r = (((op == 6) ? 32 : 0) << 25) | ((s & 31) << 20) | (rs1 << 15)
                        | (op_f3[op] << 12) | (rd << 7) | 'h13;
                end else if (op <= 8) begin
                    legal = (s >= -2048 && s <= 2047);
                    r = ((s & 'hfff) << 20) | (rs1 << 15) | (op_f3[op] << 12) | (rd << 7) | 'h13;
                end
            end
            2: begin
                legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) && s >= -2048 && s <= 2047;
                r = ((s & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h03;
            end
            3: begin
                legal = (f3 <= 2) && s >= -2048 && s <= 2047;
                r = (((s >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | ((s & 31) << 7) | 'h23;
            end
            4: begin
                legal = (f3 != 2 && f3 != 3) && s >= -4096 && s <= 4094 && (s % 2 == 0);
                r = (((s >> 12) & 1) << 31) | (((s >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
                    | (f3 << 12) | (((s >> 1) & 15) << 8) | (((s >> 11) & 1) << 7) | 'h63;
            end
            5: begin
                legal = 1;
                r = (s & 32'hFFFFF000) | (rd << 7) | 'h37;
            end
            6: begin
                legal = s >= -1048576 && s <= 1048574 && (s % 2 == 0);
                r = (((s >> 20) & 1) << 31) | (((s >> 1) & 1023) << 21) | (((s >> 11) & 1) << 20)
                    | (((s >> 12) & 255) << 12) | (rd << 7) | 'h6F;
            end
            default: legal = 0;
        endcase
        w = r;
    endfunction

    // Runs at every negedge: checks consumed words in order and models accepted requests.
    task automatic scoreboard();
        logic [31:0] ew, ea;
        bit          legal;
        if (rst) return;
        if (word_valid && word_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL word_unexpected: got data=%h addr=%h, expected no word", word_data, word_addr);
            end else begin
                ew = exp_q.pop_front();
                ea = addr_q.pop_front();
                if (word_data !== ew || word_addr !== ea) begin
                    miscompares++;
                    $display("FAIL word: got data=%h addr=%h, expected data=%h addr=%h",
                             word_data, word_addr, ew, ea);
                end
                if (exp_count != 16'hFFFF) exp_count++;
            end
        end
        if (req_valid && req_ready) begin
            ref_encode(req_fmt, req_alu_op, req_f3, req_rd, req_rs1, req_rs2, req_imm, ew, legal);
            if (legal) begin
                exp_q.push_back(ew);
                addr_q.push_back(base + 32'(4 * pushed));
                pushed++;
            end else begin
                exp_err = 1'b1;
            end
        end
    endtask

    task automatic observe();
        @(negedge clk);
        scoreboard();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) word_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_start(input logic [31:0] a);
        start = 1'b1; start_addr = a;
        base = a & 32'hFFFF_FFFC; pushed = 0; exp_err = 1'b0; exp_count = 0;
        exp_q.delete(); addr_q.delete();
        observe(); step();
        start = 1'b0;
        observe();
        vectors++;
        if (dut_state !== ST_RUN || word_addr !== base || word_count !== 16'd0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL start: got state=%0d addr=%h count=%0d err=%b, expected state=%0d addr=%h count=0 err=0",
                     dut_state, word_addr, word_count, err, ST_RUN, base);
        end
        step();
    endtask

    task automatic send(input logic [2:0] fmt, input logic [3:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        bit got;
        got = 0;
        req_fmt = fmt; req_alu_op = op; req_f3 = f3; req_rd = rd; req_rs1 = rs1;
        req_rs2 = rs2; req_imm = imm; req_valid = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            observe();
            got = req_ready;
            step();
        end
        req_valid = 1'b0;
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: got req_ready=0 for 200 cycles, expected accept");
        end
    endtask

    task automatic wait_drain();
        bit empty;
        empty = 0;
        for (int n = 0; n < 200 && !empty; n++) begin
            observe();
            empty = (exp_q.size() == 0) && !word_valid;
            step();
        end
        if (!empty) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
        end
    endtask

    task automatic do_finish();
        bit seen;
        seen = 0;
        word_ready = 1'b1;
`ifdef INSTR_ENC_TERMINATOR_EN
        exp_q.push_back(TERMINATOR);
        addr_q.push_back(base + 32'(4 * pushed));
        pushed++;
`endif
        finish = 1'b1;
        observe(); step();
        finish = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            observe();
            seen = done;
            step();
        end
        observe();
        vectors++;
        if (!seen || dut_state !== ST_IDLE || exp_q.size() != 0 || word_count !== exp_count) begin
            miscompares++;
            $display("FAIL finish: got done=%b state=%0d pending=%0d count=%0d, expected done=1 state=0 pending=0 count=%0d",
                     seen, dut_state, exp_q.size(), word_count, exp_count);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: got done=%b after return to idle, expected 0", done);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin observe(); step(); end
        observe();
        vectors++;
        if (req_ready !== 1'b0 || word_valid !== 1'b0 || word_data !== 32'd0 || word_addr !== 32'd0 ||
            done !== 1'b0 || err !== 1'b0 || word_count !== 16'd0 || dut_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset: got rdy=%b vld=%b data=%h addr=%h done=%b err=%b cnt=%0d st=%0d, expected all 0",
                     req_ready, word_valid, word_data, word_addr, done, err, word_count, dut_state);
        end
        step();
        rst = 1'b0;
        req_valid = 1'b1;
        observe();
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready: got req_ready=%b in idle, expected 0", req_ready);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] kw[5] = '{32'h00500093, 32'h402081B3, 32'h0020A423, 32'hFE208EE3, 32'h123452B7};
        word_ready = 1'b1;
        do_start(32'h100);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: send(FMT_I, ALU_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
                1: send(FMT_R, ALU_SUB, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
                2: send(FMT_S, 4'd0, 3'b010, 5'd0, 5'd1, 5'd2, 32'd8);
                3: send(FMT_B, 4'd0, 3'b000, 5'd0, 5'd1, 5'd2, -32'sd4);
                default: send(FMT_U, 4'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
            endcase
            observe();
            vectors++;
            if (word_valid !== 1'b1 || word_data !== kw[i] || word_addr !== 32'h100 + 32'(4 * i)) begin
                miscompares++;
                $display("FAIL directed_%0d: got vld=%b data=%h addr=%h, expected vld=1 data=%h addr=%h",
                         i, word_valid, word_data, word_addr, kw[i], 32'h100 + 32'(4 * i));
            end
            step();
        end
        do_finish();
    endtask

    task automatic test_back_to_back();
        bit got;
        logic [31:0] hold_w, hold_a;
        got = 0;
        word_ready = 1'b0;
        do_start(32'h200);
        send(FMT_I, ALU_XOR, 3'd0, 5'd7, 5'd6, 5'd0, 32'h7FF);
        hold_w = exp_q[0]; hold_a = addr_q[0];
        req_fmt = FMT_R; req_alu_op = ALU_AND; req_rd = 5'd4; req_rs1 = 5'd1; req_rs2 = 5'd2;
        req_valid = 1'b1;
        repeat (5) begin
            observe();
            vectors++;
            if (word_valid !== 1'b1 || word_data !== hold_w || word_addr !== hold_a || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall: got vld=%b data=%h addr=%h rdy=%b, expected vld=1 data=%h addr=%h rdy=0",
                         word_valid, word_data, word_addr, req_ready, hold_w, hold_a);
            end
            step();
        end
        word_ready = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            observe();
            got = req_ready;
            step();
        end
        req_valid = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL stall_release: got req_ready=0, expected accept after word_ready");
        end
        // Keep a steady stream to exercise accept-and-drain in the same cycle.
        for (int i = 0; i < 6; i++) send(FMT_I, ALU_ADD, 3'd0, 5'(i), 5'd1, 5'd0, 32'(i * 3 - 5));
        wait_drain();
        do_finish();
    endtask

    task automatic test_illegal();
        word_ready = 1'b1;
        do_start(32'h300);
        send(FMT_I, ALU_SUB, 3'd0, 5'd1, 5'd1, 5'd0, 32'd1);
        send(FMT_B, 4'd0, 3'b000, 5'd0, 5'd1, 5'd2, 32'd3);
        wait_drain();
        observe();
        vectors++;
        if (err !== 1'b1 || word_count !== 16'd0 || exp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal: got err=%b count=%0d, expected err=1 count=0", err, word_count);
        end
        step();
        send(FMT_J, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, -32'sd8);
        wait_drain();
        observe();
        vectors++;
        if (err !== 1'b1 || word_count !== 16'd1) begin
            miscompares++;
            $display("FAIL after_illegal: got err=%b count=%0d, expected err=1 count=1", err, word_count);
        end
        step();
        do_finish();
    endtask

    task automatic test_finish();
        word_ready = 1'b1;
        do_start(32'h400);
        for (int i = 0; i < 3; i++) send(FMT_LOAD, 4'd0, 3'b010, 5'(i + 1), 5'd2, 5'd0, 32'(4 * i));
        do_finish();
    endtask

    task automatic test_random();
        int imm_edges[12] = '{2047, -2048, 2048, 4094, -4096, 4096, 1048574, -1048576, 1048576, 31, 32, -1};
        logic [31:0] imm;
        int r;
        do_start(32'hFFFF_FFF7);
        rand_mode = 1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: imm = 32'($signed($urandom_range(0, 63)) - 16);
                1: imm = 32'(imm_edges[$urandom_range(0, 11)]);
                2: imm = 32'(2 * ($signed($urandom_range(0, 5000)) - 2500));
                default: imm = $urandom;
            endcase
            r = $urandom_range(0, 15);
            send((r < 14) ? 3'(r % 7) : 3'd7, 4'($urandom_range(0, 11)), 3'($urandom_range(0, 7)),
                 5'($urandom), 5'($urandom), 5'($urandom), imm);
        end
        rand_mode = 0;
        word_ready = 1'b1;
        wait_drain();
        observe();
        vectors++;
        if (word_count !== exp_count || err !== exp_err) begin
            miscompares++;
            $display("FAIL random_totals: got count=%0d err=%b, expected count=%0d err=%b",
                     word_count, err, exp_count, exp_err);
        end
        step();
        do_finish();
    endtask

    task automatic test_rst_mid();
        word_ready = 1'b0;
        do_start(32'h40);
        send(FMT_R, ALU_ADD, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete(); addr_q.delete();
        observe();
        vectors++;
        if (word_valid !== 1'b0 || dut_state !== ST_IDLE || word_addr !== 32'd0 || word_count !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_mid: got vld=%b state=%0d addr=%h count=%0d, expected vld=0 state=0 addr=0 count=0",
                     word_valid, dut_state, word_addr, word_count);
        end
        step();
        word_ready = 1'b1;
        req_valid = 1'b1;
        repeat (4) begin
            observe();
            vectors++;
            if (req_ready !== 1'b0 || word_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_idle: got rdy=%b vld=%b, expected rdy=0 vld=0", req_ready, word_valid);
            end
            step();
        end
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0; req_valid = 1'b0; word_ready = 1'b0;
        start_addr = '0; req_imm = '0; req_fmt = '0; req_f3 = '0; req_alu_op = '0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        base = '0; pushed = 0; exp_err = 1'b0; exp_count = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_illegal();
        test_finish();
        test_random();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
